// File: rtl/lattice_result_collector_if.sv
// Host-side and chain-side signals of the lattice result collector, bundled for port hookup.
// The slave modport is the collector's view; the master modport is the driver's view.
interface lattice_result_collector_if #(
    parameter int unsigned LOG2_NUM_CORES = 1,
    parameter int unsigned NONCE_BITS     = 32
);
    logic                      start;
    logic                      res_valid;
    logic                      res_success;
    logic [LOG2_NUM_CORES-1:0] res_index;
    logic                      hit_valid;
    logic                      hit_ready;
    logic [NONCE_BITS-1:0]     hit_nonce;
    logic                      job_done;
    logic                      overflow;
    logic                      busy;

    modport slave (
        input  start, res_valid, res_success, res_index, hit_ready,
        output hit_valid, hit_nonce, job_done, overflow, busy
    );

    modport master (
        output start, res_valid, res_success, res_index, hit_ready,
        input  hit_valid, hit_nonce, job_done, overflow, busy
    );
endinterface

// File: rtl/lattice_result_collector.sv
// Collects per-round hit reports from the lattice chain, rebuilds full nonces and queues them
// in a small FIFO for the host; flags job completion once every round is seen and drained.
module lattice_result_collector #(
    parameter int unsigned LOG2_NUM_CORES = 1,
    parameter int unsigned NONCE_BITS     = 32,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic                       clk,
    input logic                       rst,
    lattice_result_collector_if.slave bus
);
    localparam int unsigned RoundBits = NONCE_BITS - LOG2_NUM_CORES;
    localparam int unsigned AddrBits  = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrBits   = AddrBits + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    state_e                 r_state;
    logic [RoundBits-1:0]   r_round;
    logic [NONCE_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [PtrBits-1:0]     r_wr_ptr;
    logic [PtrBits-1:0]     r_rd_ptr;
    logic                   r_hit_valid;
    logic [NONCE_BITS-1:0]  r_hit_nonce;
    logic                   r_overflow;
    logic                   r_job_done;
    logic                   r_busy;

    logic                   w_beat;
    logic                   w_push_req;
    logic [NONCE_BITS-1:0]  w_push_data;
    logic [PtrBits-1:0]     w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [PtrBits-1:0]     w_wr_next;
    logic [PtrBits-1:0]     w_rd_next;
    logic [AddrBits-1:0]    w_head_slot;
    logic [NONCE_BITS-1:0]  w_head_next;

    // A start in the same cycle discards the beat.
    assign w_beat      = (r_state == StCollect) && bus.res_valid && !bus.start;
    assign w_push_req  = w_beat && bus.res_success;
    assign w_push_data = {r_round, bus.res_index};
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == PtrBits'(FIFO_DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_pop       = r_hit_valid && bus.hit_ready;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;

    always_comb begin
        w_wr_next = r_wr_ptr;
        w_rd_next = r_rd_ptr;
        if (bus.start) begin
            w_wr_next = '0;
            w_rd_next = '0;
        end else begin
            if (w_push) w_wr_next = r_wr_ptr + PtrBits'(1);
            if (w_pop)  w_rd_next = r_rd_ptr + PtrBits'(1);
        end
        // Next head may be the entry being written this very cycle.
        w_head_slot = w_rd_next[AddrBits-1:0];
        if (w_push && (w_head_slot == r_wr_ptr[AddrBits-1:0])) begin
            w_head_next = w_push_data;
        end else begin
            w_head_next = r_mem[w_head_slot];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AddrBits-1:0]] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_hit_valid <= 1'b0;
            r_hit_nonce <= '0;
        end else begin
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_hit_valid <= (w_wr_next != w_rd_next);
            r_hit_nonce <= w_head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_round    <= '0;
            r_overflow <= 1'b0;
            r_job_done <= 1'b0;
            r_busy     <= 1'b0;
        end else if (bus.start) begin
            r_state    <= StCollect;
            r_round    <= '0;
            r_overflow <= 1'b0;
            r_job_done <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                StCollect: begin
                    if (w_beat) begin
                        r_round <= r_round + RoundBits'(1);
                        if (w_drop) r_overflow <= 1'b1;
                        if (r_round == '1) r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_empty) begin
                        r_state    <= StDone;
                        r_busy     <= 1'b0;
                        r_job_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hit_valid = r_hit_valid;
    assign bus.hit_nonce = r_hit_nonce;
    assign bus.job_done  = r_job_done;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_lattice_result_collector.sv
// Directed bench for lattice_result_collector with a 6-bit nonce and two cores:
// a vector table for single-cycle behaviour plus hand sequences for job-level corners.
module tb_lattice_result_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lattice_result_collector_if #(.LOG2_NUM_CORES(1), .NONCE_BITS(6)) bus ();

    lattice_result_collector #(
        .LOG2_NUM_CORES(1),
        .NONCE_BITS    (6),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       st, rv, rs, ri, rdy;
        logic       hv;
        logic [5:0] nonce;
        logic       ov, jd, bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic rv, logic rs, logic ri, logic rdy,
                                logic hv, logic [5:0] nonce, logic ov, logic jd, logic bsy);
        vec_t v;
        v.st = st; v.rv = rv; v.rs = rs; v.ri = ri; v.rdy = rdy;
        v.hv = hv; v.nonce = nonce; v.ov = ov; v.jd = jd; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; sample just after the rising edge.
    task automatic step(input logic st, input logic rv, input logic rs, input logic ri,
                        input logic rdy);
        @(negedge clk);
        bus.start       = st;
        bus.res_valid   = rv;
        bus.res_success = rs;
        bus.res_index   = ri;
        bus.hit_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic hv, input logic [5:0] nonce,
                           input logic ov, input logic jd, input logic bsy);
        chk({tag, ".hit_valid"}, 32'(bus.hit_valid), 32'(hv));
        if (hv) chk({tag, ".hit_nonce"}, 32'(bus.hit_nonce), 32'(nonce));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
        chk({tag, ".job_done"}, 32'(bus.job_done), 32'(jd));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    endtask

    initial begin
        bus.start = 0; bus.res_valid = 0; bus.res_success = 0;
        bus.res_index = 0; bus.hit_ready = 0;

        // Table: single hit at round 5, overflow with stalled host, full FIFO push+pop.
        vecs.push_back(mk(1,0,0,0,0, 0,6'h00,0,0,1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,0,0,0, 0,6'h00,0,0,1));
        vecs.push_back(mk(0,1,1,1,0, 1,6'h0B,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 1,6'h0B,0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0,6'h00,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 0,6'h00,0,0,1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,1,0,0, 1,6'h00,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 1,6'h00,1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,6'h02,1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,6'h04,1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,6'h06,1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0,6'h00,1,0,1));
        vecs.push_back(mk(1,0,0,0,0, 0,6'h00,0,0,1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,1,0,0, 1,6'h00,0,0,1));
        vecs.push_back(mk(0,1,1,1,1, 1,6'h02,0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,6'h04,0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,6'h06,0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 1,6'h09,0,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0,6'h00,0,0,1));

        step(0,0,0,0,0);
        step(0,0,0,0,0);
        rst = 0;
        chk_out("reset", 0, 6'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].rv, vecs[i].rs, vecs[i].ri, vecs[i].rdy);
            chk_out($sformatf("vec%0d", i), vecs[i].hv, vecs[i].nonce, vecs[i].ov,
                    vecs[i].jd, vecs[i].bsy);
        end

        // Full 32-round job, hit in the final round; done only after it is popped.
        step(1,0,0,0,0);
        for (int i = 0; i < 31; i++) step(0,1,0,0,0);
        step(0,1,1,0,0);
        chk_out("last_hit", 1, 6'h3E, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0,0,0,0,0);
            chk_out("drain_hold", 1, 6'h3E, 0, 0, 1);
        end
        step(0,0,0,0,1);
        chk_out("drain_pop", 0, 6'h00, 0, 0, 1);
        step(0,0,0,0,0);
        chk_out("done", 0, 6'h00, 0, 1, 0);
        step(0,1,1,1,0);
        chk_out("done_ignores", 0, 6'h00, 0, 1, 0);

        // No-hit job: DRAIN one cycle after the final beat, DONE the cycle after.
        step(1,0,0,0,0);
        for (int i = 0; i < 32; i++) step(0,1,0,0,0);
        chk_out("nohit_drain", 0, 6'h00, 0, 0, 1);
        step(0,0,0,0,0);
        chk_out("nohit_done", 0, 6'h00, 0, 1, 0);

        // Abort at round 10 with two queued hits; the coincident beat is discarded.
        step(1,0,0,0,0);
        for (int r = 0; r < 10; r++) step(0, 1, (r == 3 || r == 7), 0, 0);
        chk_out("abort_pre", 1, 6'h06, 0, 0, 1);
        step(1,1,1,0,0);
        chk_out("abort", 0, 6'h00, 0, 0, 1);
        step(0,1,1,1,0);
        chk_out("abort_hit", 1, 6'h01, 0, 0, 1);
        for (int r = 1; r < 5; r++) step(0,1,1,0,0);
        chk_out("abort_ovf", 1, 6'h01, 1, 0, 1);

        // Reset mid-job clears everything and returns to IDLE.
        rst = 1;
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        chk_out("midreset", 0, 6'h00, 0, 0, 0);
        rst = 0;
        step(0,1,1,1,0);
        chk_out("idle_ignores", 0, 6'h00, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
